// File: rtl/grf_pkg.sv
// Shared constants for the general register file and the decode/hazard unit.
package grf_pkg;

  localparam int GRF_DATA_W   = 32;
  localparam int GRF_ADDR_W   = 5;
  localparam int GRF_ZERO_REG = 0;

  // Number of architectural registers addressed by an aw-bit register index.
  function automatic int grf_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/grf_mp_if.sv
// Register-file bus: read ports, two write ports and the scoreboard controls.
// master = decode/writeback side, slave = the register file.
interface grf_mp_if
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;

  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;

  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic [ADDR_W:0]          busy_cnt;
  logic                     sb_err;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, sb_set, sb_addr,
    input  rd_data, rd_busy, busy_cnt, sb_err
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, sb_set, sb_addr,
    output rd_data, rd_busy, busy_cnt, sb_err
  );

endinterface

// File: rtl/grf_scoreboard.sv
// Pending-register scoreboard: one bit per register awaiting a long-latency
// result, a registered count of pending registers and a double-issue error pulse.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
  output logic [NUM_RD-1:0]        lk_busy,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     sb_err
);

  localparam int DEPTH = grf_depth(ADDR_W);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(GRF_ZERO_REG);

  logic [DEPTH-1:0] pend_reg;
  logic [DEPTH-1:0] pend_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             err_reg;
  logic             err_next;
  logic             set_hit;
  logic             clr_hit;

  // Next pending vector: clear first so a same-cycle set on the same register wins.
  always_comb begin
    set_hit   = sb_set && (sb_addr != ZERO_ADDR);
    clr_hit   = clr_en && (clr_addr != ZERO_ADDR);
    pend_next = pend_reg;
    if (clr_hit) pend_next[clr_addr] = 1'b0;
    if (set_hit) pend_next[sb_addr]  = 1'b1;
    err_next  = set_hit && pend_reg[sb_addr] && !(clr_hit && (clr_addr == sb_addr));
    cnt_next  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + CNT_W'(pend_next[i]);
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
      err_reg  <= err_next;
    end
  end

  assign busy_cnt = cnt_reg;
  assign sb_err   = err_reg;

  // Per-read-port lookup of the current pending bit.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_lookup
    assign lk_busy[gi] = pend_reg[lk_addr[gi*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with pending scoreboard.
// Build option: define GRF_BYPASS_EN for same-cycle write-to-read forwarding
// (zero-cycle write->read latency); without it reads come from the array only.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input logic     clk,
  input logic     reset,
  grf_mp_if.slave bus
);

  localparam int DEPTH = grf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(GRF_ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [NUM_RD-1:0] lk_busy;
  logic              wr0_hit;
  logic              wr1_hit;

  // Writes aimed at the zero register are discarded here once for all uses.
  assign wr0_hit = bus.wr0_en && (bus.wr0_addr != ZERO_ADDR);
  assign wr1_hit = bus.wr1_en && (bus.wr1_addr != ZERO_ADDR);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi == GRF_ZERO_REG) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] q_reg;
      // Register storage; the pipeline port has priority over the long-latency port.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q_reg <= '0;
        end else if (wr0_hit && (bus.wr0_addr == ADDR_W'(gi))) begin
          q_reg <= bus.wr0_data;
        end else if (wr1_hit && (bus.wr1_addr == ADDR_W'(gi))) begin
          q_reg <= bus.wr1_data;
        end
      end
      assign regs[gi] = q_reg;
    end
  end

  // A long-latency writeback is what retires a pending register.
  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .sb_set   (bus.sb_set),
    .sb_addr  (bus.sb_addr),
    .clr_en   (bus.wr1_en),
    .clr_addr (bus.wr1_addr),
    .lk_addr  (bus.rd_addr),
    .lk_busy  (lk_busy),
    .busy_cnt (bus.busy_cnt),
    .sb_err   (bus.sb_err)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef GRF_BYPASS_EN
    logic [DATA_W-1:0] data;
    logic              busy;
    // Forward the in-flight write to this read port; wr0 beats wr1, the
    // zero register never forwards because both hits exclude it.
    always_comb begin
      data = regs[ra];
      busy = lk_busy[gi];
      if (wr0_hit && (bus.wr0_addr == ra)) begin
        data = bus.wr0_data;
      end else if (wr1_hit && (bus.wr1_addr == ra)) begin
        data = bus.wr1_data;
      end
      if (wr1_hit && (bus.wr1_addr == ra) && !(bus.sb_set && (bus.sb_addr == ra))) begin
        busy = 1'b0;
      end
    end
    assign bus.rd_data[gi*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[gi]                  = busy;
`else
    assign bus.rd_data[gi*DATA_W +: DATA_W] = regs[ra];
    assign bus.rd_busy[gi]                  = lk_busy[gi];
`endif
  end

endmodule
